uart_fixed_parser: RTL and testbench



---
 rtl/uart_fixed_parser.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_fixed_parser.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fixed_parser.sv
// Streaming ASCII "<P|S><ch>:<int>[.<frac>]\n" parser that converts to fixed point digit by digit,
// keeps one price and one threshold register per channel, and flags malformed or stalled messages.
module uart_fixed_parser #(
    parameter int VAL_W       = 16,
    parameter int NUM_CH      = 4,
    parameter int FRAC_DIGITS = 2,
    parameter int TIMEOUT_CYC = 50000,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_byte,
    input  logic                    rx_valid,
    output logic [NUM_CH*VAL_W-1:0] price,
    output logic [NUM_CH*VAL_W-1:0] threshold,
    output logic                    new_price,
    output logic                    new_threshold,
    output logic [CH_W-1:0]         upd_ch,
    output logic                    err,
    output logic [2:0]              err_code,
    output logic                    busy
);

    localparam int MAC_W = VAL_W + 4;
    localparam int FC_W  = (FRAC_DIGITS > 0) ? $clog2(FRAC_DIGITS + 1) : 1;
    localparam int TO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_DOT   = 8'h2E;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_P     = 8'h50;
    localparam logic [7:0] ASC_S     = 8'h53;
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;
    localparam logic [7:0] CH_END    = 8'(48 + NUM_CH);

    typedef enum logic [2:0] {
        S_IDLE, S_CHAN, S_COLON, S_INT, S_FRAC, S_PAD, S_COMMIT, S_FLUSH
    } state_t;

    typedef enum logic [2:0] {
        E_NONE     = 3'd0,
        E_BAD_CHAN = 3'd1,
        E_BAD_CHAR = 3'd2,
        E_OVERFLOW = 3'd3,
        E_TIMEOUT  = 3'd4,
        E_EMPTY    = 3'd5
    } err_t;

    state_t            r_state, w_state_nxt;
    logic [VAL_W-1:0]  r_acc, w_acc_nxt;
    logic [FC_W-1:0]   r_frac, w_frac_nxt, w_frac_inc;
    logic              r_any, w_any_nxt;
    logic              r_is_thr, w_is_thr_nxt;
    logic [CH_W-1:0]   r_ch, w_ch_nxt;
    logic [TO_W-1:0]   r_to_cnt, w_to_nxt;
    logic              w_err_nxt;
    logic [2:0]        w_code_nxt;
    err_t              w_fault;
    logic              w_commit, w_end, w_to_idle;
    logic              w_timed, w_to_hit, w_is_digit, w_ch_ok, w_frac_room;
    logic [3:0]        w_digit;
    logic [MAC_W-1:0]  w_mul, w_mac;
    logic              w_mul_ovf, w_mac_ovf;

    assign w_is_digit  = (rx_byte >= ASC_0) && (rx_byte <= ASC_9);
    assign w_ch_ok     = (rx_byte >= ASC_0) && (rx_byte < CH_END);
    assign w_digit     = rx_byte[3:0];
    assign w_frac_inc  = r_frac + 1'b1;
    assign w_frac_room = r_frac < FC_W'(FRAC_DIGITS);

    // Accumulator arithmetic runs 4 bits wide of the stored value so any x10+9 result is exact.
    assign w_mul     = {4'b0000, r_acc} * MAC_W'(10);
    assign w_mac     = w_mul + MAC_W'(w_digit);
    assign w_mul_ovf = |w_mul[MAC_W-1:VAL_W];
    assign w_mac_ovf = |w_mac[MAC_W-1:VAL_W];

    assign w_timed  = r_state inside {S_CHAN, S_COLON, S_INT, S_FRAC, S_FLUSH};
    assign w_to_hit = (TIMEOUT_CYC != 0) && w_timed && !rx_valid
                      && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    assign busy = (r_state != S_IDLE);

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_frac_nxt   = r_frac;
        w_any_nxt    = r_any;
        w_is_thr_nxt = r_is_thr;
        w_ch_nxt     = r_ch;
        w_to_nxt     = (w_timed && !rx_valid) ? r_to_cnt + 1'b1 : '0;
        w_err_nxt    = 1'b0;
        w_code_nxt   = err_code;
        w_fault      = E_NONE;
        w_commit     = 1'b0;
        w_end        = 1'b0;
        w_to_idle    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (rx_valid && (rx_byte == ASC_P || rx_byte == ASC_S)) begin
                    w_is_thr_nxt = (rx_byte == ASC_S);
                    w_state_nxt  = S_CHAN;
                end
            end
            S_CHAN: begin
                if (rx_valid) begin
                    if (w_ch_ok) begin
                        w_ch_nxt    = CH_W'(w_digit);
                        w_state_nxt = S_COLON;
                    end else begin
                        w_fault = E_BAD_CHAN;
                    end
                end
            end
            S_COLON: begin
                if (rx_valid) begin
                    if (rx_byte == ASC_COLON) begin
                        w_acc_nxt   = '0;
                        w_frac_nxt  = '0;
                        w_any_nxt   = 1'b0;
                        w_state_nxt = S_INT;
                    end else begin
                        w_fault = E_BAD_CHAR;
                    end
                end
            end
            S_INT: begin
                if (rx_valid) begin
                    if (w_is_digit) begin
                        if (w_mac_ovf) begin
                            w_fault = E_OVERFLOW;
                        end else begin
                            w_acc_nxt = w_mac[VAL_W-1:0];
                            w_any_nxt = 1'b1;
                        end
                    end else if (rx_byte == ASC_DOT) begin
                        w_state_nxt = S_FRAC;
                    end else if (rx_byte == ASC_LF) begin
                        w_end = 1'b1;
                    end else if (rx_byte != ASC_CR) begin
                        w_fault = E_BAD_CHAR;
                    end
                end
            end
            S_FRAC: begin
                if (rx_valid) begin
                    if (w_is_digit) begin
                        // Digits past the implied precision are range-checked, then dropped.
                        if (w_mac_ovf) begin
                            w_fault = E_OVERFLOW;
                        end else begin
                            w_any_nxt = 1'b1;
                            if (w_frac_room) begin
                                w_acc_nxt  = w_mac[VAL_W-1:0];
                                w_frac_nxt = w_frac_inc;
                            end
                        end
                    end else if (rx_byte == ASC_LF) begin
                        w_end = 1'b1;
                    end else if (rx_byte != ASC_CR) begin
                        w_fault = E_BAD_CHAR;
                    end
                end
            end
            S_PAD: begin
                if (w_mul_ovf) begin
                    w_fault   = E_OVERFLOW;
                    w_to_idle = 1'b1;
                end else begin
                    w_acc_nxt  = w_mul[VAL_W-1:0];
                    w_frac_nxt = w_frac_inc;
                    if (w_frac_inc >= FC_W'(FRAC_DIGITS)) w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_FLUSH: begin
                if (rx_valid && rx_byte == ASC_LF) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_end) begin
            if (!r_any)           w_fault     = E_EMPTY;
            else if (w_frac_room) w_state_nxt = S_PAD;
            else                  w_state_nxt = S_COMMIT;
        end

        if (w_to_hit) begin
            w_state_nxt = S_IDLE;
            if (r_state != S_FLUSH) begin
                w_fault   = E_TIMEOUT;
                w_to_idle = 1'b1;
            end
        end

        // The terminating '\n' of a bad message has already arrived, so skip FLUSH.
        if (w_fault != E_NONE) begin
            w_err_nxt   = 1'b1;
            w_code_nxt  = w_fault;
            w_state_nxt = (w_to_idle || rx_byte == ASC_LF) ? S_IDLE : S_FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the value registers drive outputs directly, so they are reset like any control flop.
            r_state       <= S_IDLE;
            r_acc         <= '0;
            r_frac        <= '0;
            r_any         <= 1'b0;
            r_is_thr      <= 1'b0;
            r_ch          <= '0;
            r_to_cnt      <= '0;
            price         <= '0;
            threshold     <= '0;
            new_price     <= 1'b0;
            new_threshold <= 1'b0;
            upd_ch        <= '0;
            err           <= 1'b0;
            err_code      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_state       <= w_state_nxt;
            r_acc         <= w_acc_nxt;
            r_frac        <= w_frac_nxt;
            r_any         <= w_any_nxt;
            r_is_thr      <= w_is_thr_nxt;
            r_ch          <= w_ch_nxt;
            r_to_cnt      <= w_to_nxt;
            new_price     <= w_commit && !r_is_thr;
            new_threshold <= w_commit && r_is_thr;
            err           <= w_err_nxt;
            err_code      <= w_code_nxt;
            if (w_commit) begin
                upd_ch <= r_ch;
                if (r_is_thr) threshold[int'(r_ch)*VAL_W +: VAL_W] <= r_acc;
                else          price[int'(r_ch)*VAL_W +: VAL_W]     <= r_acc;
            end
        end
    end

endmodule

// File: tb/tb_uart_fixed_parser.sv
// Self-checking bench: a string-level message model predicts every pulse, code and register
// value per clock; literal checks pin the model on the worked examples.
module tb_uart_fixed_parser;

    localparam int VAL_W  = 16;
    localparam int NUM_CH = 4;
    localparam int FRAC   = 2;
    localparam int TO_CYC = 100;
    localparam int MAXV   = 65535;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic [7:0]  rx_byte  = 8'h00;
    logic        rx_valid = 1'b0;
    logic [63:0] price, threshold;
    logic        new_price, new_threshold;
    logic [1:0]  upd_ch;
    logic        err;
    logic [2:0]  err_code;
    logic        busy;

    uart_fixed_parser #(
        .VAL_W(VAL_W), .NUM_CH(NUM_CH), .FRAC_DIGITS(FRAC), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .price(price), .threshold(threshold),
        .new_price(new_price), .new_threshold(new_threshold),
        .upd_ch(upd_ch), .err(err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    // kind: 0 price update, 1 threshold update, 2 error pulse
    typedef struct {
        int at;
        int kind;
        int ch;
        int val;
        int code;
    } ev_t;

    ev_t evq[$];
    int  edge_n   = 0;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  m_price[NUM_CH] = '{default: 0};
    int  m_thr[NUM_CH]   = '{default: 0};
    int  m_code = 0;
    int  m_upd  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic void push_ev(input int at, input int kind, input int ch,
                                    input int val, input int code);
        ev_t e;
        e.at = at; e.kind = kind; e.ch = ch; e.val = val; e.code = code;
        evq.push_back(e);
    endfunction

    // Byte i of m is sampled at clock edge base+i; predicts the message outcome and when it shows.
    function automatic void model_msg(input string m, input int base);
        logic [7:0] c;
        int  kind, ch, v, fr, d;
        bit  any, in_frac;
        kind = (m[0] == 8'h53) ? 1 : 0;
        c = m[1];
        if (!(c >= 8'h30 && c < 8'h30 + NUM_CH)) begin
            push_ev(base + 1, 2, 0, 0, 1);
            return;
        end
        ch = c - 8'h30;
        if (m[2] != 8'h3A) begin
            push_ev(base + 2, 2, 0, 0, 2);
            return;
        end
        v = 0; fr = 0; any = 0; in_frac = 0;
        for (int i = 3; i < m.len(); i++) begin
            c = m[i];
            if (c >= 8'h30 && c <= 8'h39) begin
                d = c - 8'h30;
                any = 1;
                if (v * 10 + d > MAXV) begin
                    push_ev(base + i, 2, 0, 0, 3);
                    return;
                end
                if (!in_frac || fr < FRAC) begin
                    v = v * 10 + d;
                    if (in_frac) fr++;
                end
            end else if (c == 8'h2E && !in_frac) begin
                in_frac = 1;
            end else if (c == 8'h0D) begin
                any = any;
            end else if (c == 8'h0A) begin
                if (!any) begin
                    push_ev(base + i, 2, 0, 0, 5);
                end else begin
                    for (int p = 1; p <= FRAC - fr; p++) begin
                        v = v * 10;
                        if (v > MAXV) begin
                            push_ev(base + i + p, 2, 0, 0, 3);
                            return;
                        end
                    end
                    push_ev(base + i + 1 + (FRAC - fr), kind, ch, v, 0);
                end
                return;
            end else begin
                push_ev(base + i, 2, 0, 0, 2);
                return;
            end
        end
    endfunction

    // Compare process: 1 time unit after every rising edge.
    always @(posedge clk) begin
        bit          enp, ent, ee;
        logic [63:0] ep, et;
        edge_n++;
        #1;
        enp = 0; ent = 0; ee = 0;
        for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].at == edge_n) begin
                case (evq[i].kind)
                    0: begin m_price[evq[i].ch] = evq[i].val; m_upd = evq[i].ch; enp = 1; end
                    1: begin m_thr[evq[i].ch] = evq[i].val; m_upd = evq[i].ch; ent = 1; end
                    default: begin m_code = evq[i].code; ee = 1; end
                endcase
                evq.delete(i);
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            ep[k*VAL_W +: VAL_W] = 16'(m_price[k]);
            et[k*VAL_W +: VAL_W] = 16'(m_thr[k]);
        end
        check("new_price", new_price, enp);
        check("new_threshold", new_threshold, ent);
        check("err", err, ee);
        check("err_code", err_code, m_code);
        check("upd_ch", upd_ch, m_upd);
        check("price", price, ep);
        check("threshold", threshold, et);
    end

    task automatic drive_bytes(input string m);
        for (int i = 0; i < m.len(); i++) begin
            @(negedge clk);
            rx_byte  = m[i];
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic send_msg(input string m, input int gap, output int base);
        @(negedge clk);
        base = edge_n + 2;
        model_msg(m, base);
        drive_bytes(m);
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("rst_price", price, 0);
        check("rst_threshold", threshold, 0);
        check("rst_busy", busy, 0);
        check("rst_code", err_code, 0);

        send_msg("P2:123.45\n", 6, base);
        check("lit_p2", price[47:32], 12345);
        check("lit_p_others", {price[63:48], price[31:0]}, 0);
        check("lit_thr_zero", threshold, 0);

        send_msg("S1:7\n", 6, base);
        check("lit_t1_700", threshold[31:16], 700);
        send_msg("S1:7.5\n", 6, base);
        check("lit_t1_750", threshold[31:16], 750);

        send_msg("P0:655.35\n", 6, base);
        check("lit_p0_max", price[15:0], 65535);
        send_msg("P0:655.36\n", 6, base);
        check("lit_code_ovf", err_code, 3);
        check("lit_p0_kept", price[15:0], 65535);
        send_msg("P0:1.999\n", 6, base);
        check("lit_p0_trunc", price[15:0], 199);

        drive_bytes("xyz\n");
        repeat (4) @(negedge clk);

        send_msg("P7:1\n", 6, base);
        check("lit_code_chan", err_code, 1);
        send_msg("P1:1x2\n", 6, base);
        check("lit_code_char", err_code, 2);
        send_msg("P1:.\n", 6, base);
        check("lit_code_empty", err_code, 5);
        send_msg("P1:3\n", 6, base);
        check("lit_p1_300", price[31:16], 300);
        send_msg("P1:6554\n", 6, base);
        check("lit_code_padovf", err_code, 3);
        check("lit_p1_kept", price[31:16], 300);
        send_msg("P3:4.2\r\n", 6, base);
        check("lit_p3_cr", price[63:48], 420);

        send_msg("P3:12", 0, base);
        push_ev(base + 4 + TO_CYC, 2, 0, 0, 4);
        repeat (10) @(negedge clk);
        check("busy_mid_msg", busy, 1);
        repeat (100) @(negedge clk);
        check("busy_after_to", busy, 0);
        check("lit_code_to", err_code, 4);
        send_msg("P3:5\n", 6, base);
        check("lit_p3_500", price[63:48], 500);

        drive_bytes("S2:9");
        check("busy_pre_rst", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_price", price, 0);
        check("arst_threshold", threshold, 0);
        check("arst_pulses", {new_price, new_threshold, err}, 0);
        check("arst_code", err_code, 0);
        check("arst_upd", upd_ch, 0);
        check("arst_busy", busy, 0);
        evq.delete();
        for (int k = 0; k < NUM_CH; k++) begin
            m_price[k] = 0;
            m_thr[k]   = 0;
        end
        m_code = 0;
        m_upd  = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send_msg("S2:99\n", 6, base);
        check("lit_t2_9900", threshold[47:32], 9900);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
